// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter in front of the PicoSoC valid/ready memory bus,
// with a bus watchdog that force-completes transactions the slave never answers.
module picosoc_bus_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout_irq
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic        last, last_nx;
  logic [1:0]  grant_q, grant_nx;
  logic [15:0] wd_cnt, wd_cnt_nx;
  logic        irq_q, irq_nx;

  logic        busy;
  logic        sel;
  logic        req_valid;
  logic        wd_fire;
  logic        done;
  logic        pick;
  logic [31:0] rdata_fwd;

  // Decode of the current transaction; everything here is combinational so the
  // slave-to-master ready/rdata path adds no latency.
  always_comb begin
    busy      = (state == BUSY);
    sel       = grant_q[1];
    req_valid = sel ? m1_valid : m0_valid;
    wd_fire   = busy && req_valid && !s_ready &&
                (TIMEOUT_CYCLES != 16'd0) && (wd_cnt == TIMEOUT_CYCLES);
    done      = busy && req_valid && (s_ready || wd_fire);
    rdata_fwd = wd_fire ? TIMEOUT_RDATA : s_rdata;
  end

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (busy) begin
      s_valid = req_valid && !wd_fire;
      s_addr  = sel ? m1_addr  : m0_addr;
      s_wdata = sel ? m1_wdata : m0_wdata;
      // A timed-out write never reaches the slave, so its strobes are suppressed too.
      s_wstrb = wd_fire ? 4'b0000 : (sel ? m1_wstrb : m0_wstrb);
      if (sel) begin
        m1_ready = done;
        m1_rdata = rdata_fwd;
      end else begin
        m0_ready = done;
        m0_rdata = rdata_fwd;
      end
    end
  end

  assign grant       = grant_q;
  assign timeout_irq = irq_q;

  // Next-state logic; on contention the master that was not served last wins.
  always_comb begin
    state_nx  = state;
    last_nx   = last;
    grant_nx  = grant_q;
    wd_cnt_nx = wd_cnt;
    irq_nx    = 1'b0;
    pick      = m1_valid;
    if (m0_valid && m1_valid) begin
      pick = ~last;
    end
    unique case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nx  = BUSY;
          grant_nx  = pick ? 2'b10 : 2'b01;
          wd_cnt_nx = '0;
        end
      end
      BUSY: begin
        if (done) begin
          state_nx = IDLE;
          last_nx  = sel;
          grant_nx = 2'b00;
          irq_nx   = wd_fire;
        end else if (!req_valid) begin
          state_nx = IDLE;
          grant_nx = 2'b00;
        end else if (wd_cnt != 16'hFFFF) begin
          wd_cnt_nx = wd_cnt + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      last    <= 1'b1;
      grant_q <= 2'b00;
      wd_cnt  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      grant_q <= grant_nx;
      wd_cnt  <= wd_cnt_nx;
      irq_q   <= irq_nx;
    end
  end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Bench for picosoc_bus_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_picosoc_bus_arbiter;

  localparam logic [15:0] TO_N  = 16'd8;
  localparam logic [31:0] TO_RD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_irq;

  picosoc_bus_arbiter #(
    .TIMEOUT_CYCLES (TO_N),
    .TIMEOUT_RDATA  (TO_RD)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0_valid    (m0_valid),
    .m0_ready    (m0_ready),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_wstrb    (m0_wstrb),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_ready    (m1_ready),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_wstrb    (m1_wstrb),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_rdata     (s_rdata),
    .grant       (grant),
    .timeout_irq (timeout_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: run did not finish in time");
    $fatal(1, "time limit");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner of the bus (-1 when free), last served master,
  // cycles the slave has left the owner waiting, and a pending irq pulse.
  int owner = -1;
  int last_served = 1;
  int waited = 0;
  bit irq_pend = 1'b0;
  bit known = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] gseq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic v0, input logic v1, input logic sr);
    m0_valid = v0;
    m1_valid = v1;
    s_ready  = sr;
  endtask

  // Called just after a falling edge with the inputs for this cycle in place.
  task automatic cyc();
    bit mv, to, e_sv, e_rdy;
    logic [31:0] e_rd, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_grant;
    #1;
    mv      = (owner == 0) ? m0_valid : (owner == 1) ? m1_valid : 1'b0;
    to      = (owner >= 0) && mv && !s_ready && (TO_N != 16'd0) && (waited == int'(TO_N));
    e_sv    = (owner >= 0) && mv && !to;
    e_rdy   = (owner >= 0) && mv && (s_ready || to);
    e_rd    = (owner < 0) ? 32'h0 : (to ? TO_RD : s_rdata);
    e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e_addr  = (owner == 0) ? m0_addr  : (owner == 1) ? m1_addr  : 32'h0;
    e_wdata = (owner == 0) ? m0_wdata : (owner == 1) ? m1_wdata : 32'h0;
    e_wstrb = (owner == 0) ? m0_wstrb : (owner == 1) ? m1_wstrb : 4'h0;
    if (known) begin
      chk("grant",       grant,       e_grant);
      chk("s_valid",     s_valid,     e_sv);
      chk("m0_ready",    m0_ready,    e_rdy && owner == 0);
      chk("m1_ready",    m1_ready,    e_rdy && owner == 1);
      chk("m0_rdata",    m0_rdata,    (owner == 0) ? e_rd : 32'h0);
      chk("m1_rdata",    m1_rdata,    (owner == 1) ? e_rd : 32'h0);
      chk("timeout_irq", timeout_irq, irq_pend);
      chk("s_addr",      s_addr,      e_addr);
      chk("s_wdata",     s_wdata,     e_wdata);
      if (e_sv || owner < 0) chk("s_wstrb", s_wstrb, e_wstrb);
      if (grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant);
    end
    prev_grant = grant;
    if (!resetn) begin
      owner = -1; last_served = 1; waited = 0; irq_pend = 1'b0; known = 1'b1;
    end else if (known) begin
      irq_pend = 1'b0;
      if (owner < 0) begin
        if (m0_valid && m1_valid) owner = 1 - last_served;
        else if (m0_valid)        owner = 0;
        else if (m1_valid)        owner = 1;
        waited = 0;
      end else if (e_rdy) begin
        last_served = owner;
        irq_pend    = to;
        owner       = -1;
      end else if (!mv) begin
        owner = -1;
      end else begin
        waited++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int rp;
    resetn = 1'b0;
    set(1'b0, 1'b0, 1'b0);
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_rdata = '0;
    @(negedge clk);
    cyc(); cyc();
    resetn = 1'b1;
    cyc();

    // Single master read, slave answers one cycle after s_valid.
    m0_addr = 32'h0000_0010; s_rdata = 32'h1234_5678;
    set(1, 0, 0); cyc(); cyc();
    set(1, 0, 1); cyc();
    set(0, 0, 0); cyc();

    // Contention right after reset: grants alternate starting with m0.
    resetn = 1'b0; cyc(); resetn = 1'b1;
    gseq.delete();
    set(1, 1, 1); repeat (8) cyc();
    set(0, 0, 0); cyc();
    chk("cont_count", gseq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("cont_seq", (gseq.size() > i) ? gseq[i] : 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10);

    // m1 write forwarded while m0 waits its turn.
    m1_addr = 32'h0200_0008; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011;
    m0_addr = 32'h0000_0100; m0_wstrb = 4'b0000;
    set(0, 1, 0); cyc();
    set(1, 1, 0); cyc();
    chk("wr_s_addr",  s_addr,  32'h0200_0008);
    set(1, 1, 1); cyc();
    set(1, 0, 0); cyc();
    set(1, 0, 1); cyc();
    set(0, 0, 0); cyc();
    m1_wstrb = 4'b0000;

    // Watchdog timeout on an m0 read: ready in the 9th busy cycle, irq after.
    s_rdata = 32'h5555_AAAA;
    set(1, 0, 0); repeat (10) cyc();
    set(0, 0, 0); repeat (2) cyc();

    // Slave answers in exactly the timeout cycle: normal completion.
    set(1, 0, 0); repeat (9) cyc();
    s_rdata = 32'hA5A5_0F0F;
    set(1, 0, 1); cyc();
    set(0, 0, 0); repeat (2) cyc();

    // Reset while m1 is waiting; afterwards m0 wins the first contention.
    set(0, 1, 0); repeat (4) cyc();
    resetn = 1'b0; cyc(); resetn = 1'b1;
    set(1, 1, 0); cyc(); cyc();
    set(1, 1, 1); cyc();
    set(0, 0, 0); cyc();

    // Random traffic in phases of varying slave responsiveness.
    rp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: rp = 3;
          1: rp = 30;
          2: rp = 70;
          default: rp = 100;
        endcase
      end
      m0_valid = m0_valid ? ($urandom_range(0, 99) >= 8) : ($urandom_range(0, 99) < 40);
      m1_valid = m1_valid ? ($urandom_range(0, 99) >= 8) : ($urandom_range(0, 99) < 40);
      s_ready  = ($urandom_range(0, 99) < rp);
      m0_addr  = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      m1_addr  = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      s_rdata  = $urandom;
      resetn   = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
